branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor paired with the EX-stage branch resolution logic.
- IF side: combinational lookup of the fetch PC in a direct-mapped table. Each entry holds valid, tag, target and a 2-bit saturating counter. Returns predicted direction and next PC.
- EX side: consumes the resolved outcome (taken flag, target address) plus the prediction carried down the pipeline. Trains the table and raises flush/redirect on mispredict.

Parameters:
- ENTRIES, 16, table depth; power of 2, minimum 2. IDX_W = log2(ENTRIES) is derived internally.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- if_pc_i  in  32  fetch-stage PC
- pred_taken_o  out  1  predicted taken for if_pc_i
- pred_target_o  out  32  predicted next PC
- ex_valid_i  in  1  EX stage holds a conditional branch
- ex_pc_i  in  32  PC of the branch in EX
- ex_taken_i  in  1  resolved direction
- ex_target_i  in  32  resolved taken target (pc + imm)
- ex_pred_taken_i  in  1  prediction made at fetch, carried down the pipeline
- ex_pred_target_i  in  32  predicted target carried down the pipeline
- stall_i  in  1  pipeline stall; blocks training and flush
- flush_o  out  1  mispredict; squash IF/ID and ID/EX
- redirect_pc_o  out  32  correct next PC when flush_o=1

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Reset (rst_i low, asynchronous):
  - all valid=0, counters=01 (WNT), targets=0.
  - pred_taken_o=0 and flush_o=0 while rst_i is low.
  - pred_target_o=if_pc_i+4, redirect_pc_o=0 while rst_i is low.
  - Reset mid-operation discards all training.
- Lookup (combinational):
  - hit = valid & tag match.
  - pred_taken_o = hit & ctr[1].
  - pred_target_o = pred_taken_o ? entry.target : if_pc_i+4 (32-bit, wraps modulo 2^32).
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
  - Taken increments; not-taken decrements.
  - Saturates at 11 and 00.
- Training occurs on the rising edge when rst_i=1 & ex_valid_i & ~stall_i:
  - hit & taken: ctr++, target<=ex_target_i.
  - hit & not taken: ctr--, target unchanged.
  - miss & taken: allocate or overwrite. valid=1, tag, target=ex_target_i, ctr=10 (WT).
  - miss & not taken: no change; an existing entry with a different tag is left intact.
- Read/write same index in the same cycle: lookup returns pre-update contents. The update is visible from the next cycle.
- Mispredict (combinational, gated by rst_i=1 & ex_valid_i & ~stall_i):
  - flush_o = (ex_taken_i != ex_pred_taken_i) | (ex_taken_i & ex_pred_taken_i & ex_target_i != ex_pred_target_i).
  - redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i+4.
  - When flush_o=0, redirect_pc_o still carries this value (don't-care for the consumer).
- ex_valid_i=0: no training, flush_o=0.
- A flushed branch still trains in the same cycle.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs br_cnt_o[31:0] and mispred_cnt_o[31:0].
  - br_cnt_o counts training events (ex_valid_i & ~stall_i).
  - mispred_cnt_o counts cycles with flush_o=1.
  - Both reset to 0 and saturate at 32'hFFFFFFFF (no wrap).
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then if_pc_i=0x100 → pred_taken_o=0, pred_target_o=0x104, flush_o=0.
- Cold miss, taken branch:
  - Stimulus: ex_valid_i=1, ex_pc_i=0x100, ex_taken_i=1, ex_target_i=0x140, ex_pred_taken_i=0.
  - Same cycle: flush_o=1, redirect_pc_o=0x140.
  - Next cycle, if_pc_i=0x100: pred_taken_o=1, pred_target_o=0x140.
- Saturation/hysteresis:
  - Train 0x100 taken 3 more times (ctr=11), then not-taken once (ctr=10) → still predicts 0x140.
  - Second not-taken (ctr=01) → pred_target_o=0x104.
- Alias, ENTRIES=16: 0x100 valid, taken branch at 0x140 (same index, different tag).
  - Entry is overwritten; lookup of 0x100 misses.
  - Not-taken miss at 0x180 leaves the 0x140 entry intact.
- Stall and same-index read/write:
  - stall_i=1 with mispredict inputs → flush_o=0, table unchanged.
  - Update and lookup of 0x100 in the same cycle → old prediction that cycle, new one next cycle.
- BP_STATS_EN defined: 5 branches, 2 mispredicts → br_cnt_o=5, mispred_cnt_o=2. Assert rst_i low mid-run → both counters 0 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped 2-bit dynamic branch predictor with EX-stage
//               mispredict detection, flush and redirect generation.
//               Optional statistics counters enabled by macro BP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    input  logic        stall_i,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o
`ifdef BP_STATS_EN
    ,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [1:0] c_CTR_SNT = 2'b00;
    localparam logic [1:0] c_CTR_WNT = 2'b01;
    localparam logic [1:0] c_CTR_WT  = 2'b10;
    localparam logic [1:0] c_CTR_ST  = 2'b11;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_train;
    logic             w_mispredict;
    logic             w_unused_ok;

    assign w_if_idx = if_pc_i[IDX_W+1:2];
    assign w_if_tag = if_pc_i[31:IDX_W+2];
    assign w_ex_idx = ex_pc_i[IDX_W+1:2];
    assign w_ex_tag = ex_pc_i[31:IDX_W+2];
    assign w_unused_ok = &{1'b0, if_pc_i[1:0], ex_pc_i[1:0]};

    // Lookup reads the registered table, so a same-cycle update shows up next cycle.
    assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken_o  = rst_i & w_if_hit & r_ctr[w_if_idx][1];
    assign pred_target_o = pred_taken_o ? r_target[w_if_idx] : (if_pc_i + 32'd4);

    assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_train      = rst_i & ex_valid_i & ~stall_i;
    assign w_mispredict = (ex_taken_i != ex_pred_taken_i) |
                          (ex_taken_i & ex_pred_taken_i & (ex_target_i != ex_pred_target_i));
    assign flush_o       = w_train & w_mispredict;
    assign redirect_pc_o = !rst_i ? 32'd0 :
                           (ex_taken_i ? ex_target_i : (ex_pc_i + 32'd4));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'd0;
                r_ctr[i]    <= c_CTR_WNT;
            end
        end else if (w_train) begin
            if (w_ex_hit) begin
                if (ex_taken_i) begin
                    r_target[w_ex_idx] <= ex_target_i;
                    if (r_ctr[w_ex_idx] != c_CTR_ST)
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                end else if (r_ctr[w_ex_idx] != c_CTR_SNT) begin
                    r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                end
            end else if (ex_taken_i) begin
                // Not-taken misses never allocate, so aliases survive them.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target_i;
                r_ctr[w_ex_idx]    <= c_CTR_WT;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_br_cnt      <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (w_train && (r_br_cnt != 32'hFFFF_FFFF))
                r_br_cnt <= r_br_cnt + 32'd1;
            if (flush_o && (r_mispred_cnt != 32'hFFFF_FFFF))
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign br_cnt_o      = r_br_cnt;
    assign mispred_cnt_o = r_mispred_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed plus random checking of branch_predictor against a
//               behavioural table model (stats checked when BP_STATS_EN set).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int ENTRIES = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_pred_target_i;
    logic        stall_i;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
`ifdef BP_STATS_EN
    logic [31:0] br_cnt_o;
    logic [31:0] mispred_cnt_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one record per table slot, counter kept as plain integer 0..3.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    longint      m_br;
    longint      m_mis;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .if_pc_i          (if_pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .ex_valid_i       (ex_valid_i),
        .ex_pc_i          (ex_pc_i),
        .ex_taken_i       (ex_taken_i),
        .ex_target_i      (ex_target_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_pred_target_i (ex_pred_target_i),
        .stall_i          (stall_i),
        .flush_o          (flush_o),
        .redirect_pc_o    (redirect_pc_o)
`ifdef BP_STATS_EN
        ,
        .br_cnt_o         (br_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'd0;
            m_tgt[i]   = 32'd0;
            m_ctr[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] ptg);
        int unsigned i;
        i   = (pc / 4) % ENTRIES;
        pt  = m_valid[i] && (m_tag[i] == pc / (4 * ENTRIES)) && (m_ctr[i] >= 2);
        ptg = pt ? m_tgt[i] : pc + 32'd4;
    endtask

    function automatic logic [31:0] rpc();
        return 32'($urandom_range(0, 47)) << 2;
    endfunction

    // One cycle: drive at negedge, check combinational outputs, then train the model.
    task automatic apply(input logic v, input logic [31:0] ipc, input logic [31:0] epc,
                         input logic tk, input logic [31:0] tg, input logic ptk,
                         input logic [31:0] ptg, input logic st);
        logic        e_pt, e_flush, hit;
        logic [31:0] e_ptg, e_redir;
        int unsigned i;
        @(negedge clk_i);
        if_pc_i = ipc; ex_valid_i = v; ex_pc_i = epc; ex_taken_i = tk;
        ex_target_i = tg; ex_pred_taken_i = ptk; ex_pred_target_i = ptg; stall_i = st;
        #1;
        model_lookup(ipc, e_pt, e_ptg);
        e_flush = v && !st && ((tk != ptk) || (tk && ptk && (tg != ptg)));
        e_redir = tk ? tg : epc + 32'd4;
        check("pred_taken", {31'd0, pred_taken_o}, {31'd0, e_pt});
        check("pred_target", pred_target_o, e_ptg);
        check("flush", {31'd0, flush_o}, {31'd0, e_flush});
        check("redirect", redirect_pc_o, e_redir);
`ifdef BP_STATS_EN
        check("br_cnt", br_cnt_o, 32'(m_br));
        check("mispred_cnt", mispred_cnt_o, 32'(m_mis));
`endif
        if (v && !st) begin
            i   = (epc / 4) % ENTRIES;
            hit = m_valid[i] && (m_tag[i] == epc / (4 * ENTRIES));
            if (hit && tk) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tg;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end else if (tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = epc / (4 * ENTRIES);
                m_tgt[i]   = tg;
                m_ctr[i]   = 2;
            end
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (e_flush && m_mis < 64'hFFFF_FFFF) m_mis++;
        end
    endtask

    // Asynchronous reset asserted away from the clock edge, with mispredict inputs live.
    task automatic do_reset(input logic [31:0] ipc);
        @(negedge clk_i);
        rst_i = 1'b0;
        if_pc_i = ipc; ex_valid_i = 1'b1; ex_pc_i = 32'h100; ex_taken_i = 1'b1;
        ex_target_i = 32'h140; ex_pred_taken_i = 1'b0; ex_pred_target_i = 32'h0; stall_i = 1'b0;
        #1;
        check("rst_pred_taken", {31'd0, pred_taken_o}, 32'd0);
        check("rst_pred_target", pred_target_o, ipc + 32'd4);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_redirect", redirect_pc_o, 32'd0);
`ifdef BP_STATS_EN
        check("rst_br_cnt", br_cnt_o, 32'd0);
        check("rst_mispred_cnt", mispred_cnt_o, 32'd0);
`endif
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        ex_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; if_pc_i = 32'h100; ex_valid_i = 1'b0; ex_pc_i = 32'h0;
        ex_taken_i = 1'b0; ex_target_i = 32'h0; ex_pred_taken_i = 1'b0;
        ex_pred_target_i = 32'h0; stall_i = 1'b0;
        model_reset();
        do_reset(32'h100);

        // Cold miss, taken: flush now, prediction next cycle.
        apply(1, 32'h100, 32'h100, 1, 32'h140, 0, 32'h104, 0);
        check("cold_flush", {31'd0, flush_o}, 32'd1);
        check("cold_redirect", redirect_pc_o, 32'h140);
        apply(0, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        check("cold_pred", pred_target_o, 32'h140);

        // Saturate, then hysteresis on not-taken.
        for (int k = 0; k < 3; k++) apply(1, 32'h100, 32'h100, 1, 32'h140, 1, 32'h140, 0);
        apply(1, 32'h100, 32'h100, 0, 32'h140, 1, 32'h140, 0);
        check("nt1_redirect", redirect_pc_o, 32'h104);
        apply(0, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        check("hyst_pred", pred_target_o, 32'h140);
        apply(1, 32'h100, 32'h100, 0, 32'h140, 1, 32'h140, 0);
        apply(0, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        check("wnt_pred", pred_target_o, 32'h104);

        // Alias at the same index, then a not-taken miss that must not disturb it.
        apply(1, 32'h140, 32'h140, 1, 32'h200, 0, 32'h144, 0);
        apply(0, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        check("alias_miss", pred_target_o, 32'h104);
        apply(1, 32'h140, 32'h180, 0, 32'h300, 0, 32'h184, 0);
        check("alias_new", pred_target_o, 32'h200);
        apply(0, 32'h140, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        check("alias_kept", pred_target_o, 32'h200);

        // Stall blocks flush and training.
        apply(1, 32'h140, 32'h140, 0, 32'h200, 1, 32'h200, 1);
        check("stall_flush", {31'd0, flush_o}, 32'd0);
        // Same-index update and lookup: old value now, new value next cycle.
        apply(1, 32'h140, 32'h140, 0, 32'h200, 1, 32'h200, 0);
        check("rw_old", pred_target_o, 32'h200);
        apply(0, 32'h140, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        check("rw_new", pred_target_o, 32'h144);

        // Address wrap at the top of the space.
        apply(1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10, 0);
        check("wrap_redirect", redirect_pc_o, 32'h0);
        check("wrap_target", pred_target_o, 32'h0);

`ifdef BP_STATS_EN
        do_reset(32'h300);
        apply(1, 32'h300, 32'h300, 1, 32'h380, 0, 32'h304, 0);
        apply(1, 32'h300, 32'h300, 1, 32'h380, 1, 32'h380, 0);
        apply(1, 32'h300, 32'h304, 0, 32'h380, 0, 32'h308, 0);
        apply(1, 32'h300, 32'h304, 0, 32'h380, 1, 32'h380, 0);
        apply(1, 32'h300, 32'h308, 0, 32'h380, 0, 32'h30c, 0);
        apply(0, 32'h300, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        check("stats_br5", br_cnt_o, 32'd5);
        check("stats_mis2", mispred_cnt_o, 32'd2);
`endif

        // Random traffic over a small PC set so indices alias frequently.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ipc, epc, tg, ptg;
            logic        v, tk, ptk, st;
            ipc = rpc();
            epc = rpc();
            v   = ($urandom_range(0, 9) < 7);
            tk  = 1'($urandom_range(0, 1));
            tg  = $urandom & 32'h0000_03FC;
            st  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) begin
                model_lookup(epc, ptk, ptg);
            end else begin
                ptk = 1'($urandom_range(0, 1));
                ptg = $urandom & 32'h0000_03FC;
            end
            apply(v, ipc, epc, tk, tg, ptk, ptg, st);
            if (k == 200) do_reset(ipc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
